hc165_chain_reader: RTL and testbench

//  Upstream controller and deserialiser for a daisy-chain of 74HC165D shift registers.
//  - Drives PL_n, CP and CE_n into the chain and samples the chain's serial Q7 back.
//  - Assembles the sampled bits into one parallel word and presents it with a 1-cycle VALID strobe.
//  - Sits between the board input pins (buttons, DIP switches) and the input-handling logic.

---
 rtl/hc165_chain_reader_pkg.sv | 25 ++
 rtl/hc165_chain_reader_sync.sv | 25 ++
 rtl/hc165_chain_reader.sv | 146 ++++++++++++++
 tb/tb_hc165_chain_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hc165_chain_reader_pkg.sv
// Shared definitions for the 74HC165 chain reader: FSM state encoding and a
// constant-friendly ceil(log2) used to size the counters.
package hc165_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/hc165_chain_reader_sync.sv
// Generic two-flop synchroniser for asynchronous inputs; clears to zero on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/hc165_chain_reader.sv
// Controller and deserialiser for a 74HC165 daisy chain: drives PL_n/CP/CE_n from
// flops and assembles the synchronised Q7 stream into DATA with a one-cycle VALID.
module hc165_chain_reader
   import hc165_pkg::*;
#(
   parameter int NUM_REGS  = 2,
   parameter int CLK_DIV   = 4,
   parameter int PL_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  START,
   input  logic                  AUTO,
   input  logic                  SER_IN,
   output logic                  PL_n,
   output logic                  CP,
   output logic                  CE_n,
   output logic [8*NUM_REGS-1:0] DATA,
   output logic                  VALID,
   output logic                  BUSY
);
   localparam int N  = 8 * NUM_REGS;
   localparam int BW = clog2(N);
   localparam int PW = clog2((CLK_DIV > PL_CYCLES) ? CLK_DIV : PL_CYCLES);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PL_LAST  = PW'(PL_CYCLES - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [N-1:0]  shreg_q, shreg_d;
   logic [N-1:0]  data_q, data_d;
   logic          pl_n_q, pl_n_d;
   logic          cp_q, cp_d;
   logic          ce_n_q, ce_n_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          ser_sync;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk   (CLK),
      .rst_n (RST_n),
      .d     (SER_IN),
      .q     (ser_sync)
   );

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (START || AUTO) begin
               state_d = LOAD;
               phase_d = '0;
            end
         end
         LOAD: begin
            if (phase_q == PL_LAST) begin
               state_d = SHIFT_LO;
               phase_d = '0;
               bit_d   = '0;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         SHIFT_LO: begin
            if (phase_q == DIV_LAST) begin
               // Sample at the end of the low phase, well after the previous CP edge settled.
               shreg_d = {shreg_q[N-2:0], ser_sync};
               phase_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = DONE;
                  data_d  = {shreg_q[N-2:0], ser_sync};
               end else begin
                  state_d = SHIFT_HI;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         SHIFT_HI: begin
            if (phase_q == DIV_LAST) begin
               state_d = SHIFT_LO;
               phase_d = '0;
               bit_d   = bit_q + BW'(1);
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         DONE: begin
            state_d = AUTO ? LOAD : IDLE;
            phase_d = '0;
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase

      // Chain controls are registered copies of the next state so they never glitch.
      pl_n_d  = (state_d != LOAD);
      cp_d    = (state_d == SHIFT_HI);
      ce_n_d  = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI));
      valid_d = (state_d == DONE);
      busy_d  = (state_d == LOAD) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         pl_n_q  <= 1'b1;
         cp_q    <= 1'b0;
         ce_n_q  <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         pl_n_q  <= pl_n_d;
         cp_q    <= cp_d;
         ce_n_q  <= ce_n_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign PL_n  = pl_n_q;
   assign CP    = cp_q;
   assign CE_n  = ce_n_q;
   assign DATA  = data_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_hc165_chain_reader.sv
// Directed bench for hc165_chain_reader: default two-device chain plus a
// single-device build with CLK_DIV=5, PL_CYCLES=1, each with behavioural 74HC165 models.
module tb_hc165_chain_reader;

   logic        CLK;
   logic        RST_n;
   logic        START, AUTO, SER_IN;
   logic        PL_n, CP, CE_n, VALID, BUSY;
   logic [15:0] DATA;

   logic        START2, AUTO2, SER_IN2;
   logic        PL_n2, CP2, CE_n2, VALID2, BUSY2;
   logic [7:0]  DATA2;

   logic [7:0]  dn0, dn1, dn2;
   logic [7:0]  u0_reg = '0;
   logic [7:0]  u1_reg = '0;
   logic [7:0]  u2_reg = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   hc165_chain_reader dut (
      .CLK(CLK), .RST_n(RST_n), .START(START), .AUTO(AUTO), .SER_IN(SER_IN),
      .PL_n(PL_n), .CP(CP), .CE_n(CE_n), .DATA(DATA), .VALID(VALID), .BUSY(BUSY)
   );

   hc165_chain_reader #(.NUM_REGS(1), .CLK_DIV(5), .PL_CYCLES(1)) dut2 (
      .CLK(CLK), .RST_n(RST_n), .START(START2), .AUTO(AUTO2), .SER_IN(SER_IN2),
      .PL_n(PL_n2), .CP(CP2), .CE_n(CE_n2), .DATA(DATA2), .VALID(VALID2), .BUSY(BUSY2)
   );

   // 74HC165 models: async parallel load while PL_n low, shift toward Q7 on CP rise.
   always @(negedge PL_n or posedge CP) begin
      if (!PL_n) begin
         u0_reg <= dn0;
         u1_reg <= dn1;
      end else if (!CE_n) begin
         u0_reg <= {u0_reg[6:0], u1_reg[7]};
         u1_reg <= {u1_reg[6:0], 1'b0};
      end
   end
   assign SER_IN = u0_reg[7];

   always @(negedge PL_n2 or posedge CP2) begin
      if (!PL_n2) u2_reg <= dn2;
      else if (!CE_n2) u2_reg <= {u2_reg[6:0], 1'b0};
   end
   assign SER_IN2 = u2_reg[7];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_scan;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int edges);
      edges = -1;
      for (int n = 1; n <= limit; n++) begin
         @(posedge CLK); #1;
         if (VALID) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST_n = 1'b0;
      #2;
      total_cnt++; if (PL_n !== 1'b1) $display("FAIL reset_pl_n got %b want 1", PL_n); else pass_cnt++;
      total_cnt++; if (CP !== 1'b0) $display("FAIL reset_cp got %b want 0", CP); else pass_cnt++;
      total_cnt++; if (CE_n !== 1'b1) $display("FAIL reset_ce_n got %b want 1", CE_n); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h0000) $display("FAIL reset_data got %h want 0000", DATA); else pass_cnt++;
      total_cnt++; if (VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", VALID); else pass_cnt++;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else pass_cnt++;
      @(posedge CLK); #1;
      RST_n = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic test_single_scan;
      int edges;
      dn0 = 8'hA5; dn1 = 8'h3C;
      start_scan();
      total_cnt++; if (BUSY !== 1'b1 || PL_n !== 1'b0) $display("FAIL single_load busy=%b pl_n=%b want 1/0", BUSY, PL_n); else pass_cnt++;
      wait_valid(300, edges);
      total_cnt++; if (edges + 1 !== 127) $display("FAIL single_latency got cycle %0d want 127", edges + 1); else pass_cnt++;
      total_cnt++; if (DATA !== 16'hA53C) $display("FAIL single_data got %h want a53c", DATA); else pass_cnt++;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL single_busy_done got %b want 0", BUSY); else pass_cnt++;
      @(posedge CLK); #1;
      total_cnt++; if (VALID !== 1'b0 || DATA !== 16'hA53C) $display("FAIL single_hold valid=%b data=%h want 0/a53c", VALID, DATA); else pass_cnt++;
   endtask

   task automatic test_start_ignored;
      int valids, vcyc;
      dn0 = 8'h5A; dn1 = 8'hC3;
      start_scan();
      valids = 0; vcyc = -1;
      for (int n = 1; n <= 250; n++) begin
         START = (n == 10 || n == 60);
         @(posedge CLK); #1;
         if (VALID) begin
            valids++;
            if (vcyc < 0) vcyc = n + 1;
         end
      end
      START = 1'b0;
      total_cnt++; if (valids !== 1) $display("FAIL ignored_count got %0d want 1", valids); else pass_cnt++;
      total_cnt++; if (vcyc !== 127) $display("FAIL ignored_latency got cycle %0d want 127", vcyc); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h5AC3) $display("FAIL ignored_data got %h want 5ac3", DATA); else pass_cnt++;
   endtask

   task automatic test_auto;
      int edges, valids;
      dn0 = 8'hFF; dn1 = 8'hFF;
      AUTO = 1'b1;
      wait_valid(300, edges);
      total_cnt++; if (edges !== 127) $display("FAIL auto_first got %0d edges want 127", edges); else pass_cnt++;
      total_cnt++; if (DATA !== 16'hFFFF) $display("FAIL auto_data_ffff got %h want ffff", DATA); else pass_cnt++;
      dn0 = 8'h00; dn1 = 8'h00;
      wait_valid(300, edges);
      total_cnt++; if (edges !== 127) $display("FAIL auto_period got %0d want 127", edges); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h0000) $display("FAIL auto_data_0000 got %h want 0000", DATA); else pass_cnt++;
      dn0 = 8'h12; dn1 = 8'h34;
      repeat (50) @(posedge CLK);
      #1;
      AUTO = 1'b0;
      wait_valid(300, edges);
      total_cnt++; if (edges !== 77) $display("FAIL auto_fall_finish got %0d edges want 77", edges); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h1234) $display("FAIL auto_data_1234 got %h want 1234", DATA); else pass_cnt++;
      valids = 0;
      for (int n = 0; n < 200; n++) begin
         @(posedge CLK); #1;
         if (VALID) valids++;
      end
      total_cnt++; if (valids !== 0 || BUSY !== 1'b0) $display("FAIL auto_stopped valids=%0d busy=%b want 0/0", valids, BUSY); else pass_cnt++;
   endtask

   task automatic test_reset_mid_scan;
      int edges;
      dn0 = 8'hA5; dn1 = 8'h3C;
      start_scan();
      repeat (64) @(posedge CLK);
      #1;
      total_cnt++; if (CP !== 1'b1 || BUSY !== 1'b1) $display("FAIL midscan_in_hi cp=%b busy=%b want 1/1", CP, BUSY); else pass_cnt++;
      RST_n = 1'b0;
      #1;
      total_cnt++; if (PL_n !== 1'b1 || CP !== 1'b0 || CE_n !== 1'b1) $display("FAIL midscan_ctrl pl_n=%b cp=%b ce_n=%b want 1/0/1", PL_n, CP, CE_n); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h0000) $display("FAIL midscan_data got %h want 0000", DATA); else pass_cnt++;
      total_cnt++; if (BUSY !== 1'b0) $display("FAIL midscan_busy got %b want 0", BUSY); else pass_cnt++;
      @(posedge CLK); #1;
      RST_n = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      dn0 = 8'h0F; dn1 = 8'hF0;
      start_scan();
      wait_valid(300, edges);
      total_cnt++; if (edges + 1 !== 127) $display("FAIL after_reset_latency got cycle %0d want 127", edges + 1); else pass_cnt++;
      total_cnt++; if (DATA !== 16'h0FF0) $display("FAIL after_reset_data got %h want 0ff0", DATA); else pass_cnt++;
   endtask

   task automatic test_protocol;
      int scans, rises, run, pl_run;
      int bad_rise, bad_phase, bad_pl, overlap, bad_data;
      logic prev_cp, prev_ce, prev_pl;
      dn0 = 8'hC6; dn1 = 8'h19;
      scans = 0; rises = 0; run = 1; pl_run = 0;
      bad_rise = 0; bad_phase = 0; bad_pl = 0; overlap = 0; bad_data = 0;
      prev_cp = CP; prev_ce = CE_n; prev_pl = PL_n;
      AUTO = 1'b1;
      for (int n = 0; n < 50 * 127 + 300 && scans < 50; n++) begin
         @(posedge CLK); #1;
         if (CP && !PL_n) overlap++;
         if (CP && !prev_cp) rises++;
         if (CP === prev_cp && CE_n === prev_ce) run++;
         else begin
            if (!prev_ce && run != 4) bad_phase++;
            run = 1;
         end
         if (!PL_n) pl_run++;
         else if (!prev_pl) begin
            if (pl_run != 2) bad_pl++;
            pl_run = 0;
         end
         if (VALID) begin
            scans++;
            if (rises != 15) bad_rise++;
            if (DATA !== 16'hC619) bad_data++;
            rises = 0;
            if (scans == 50) AUTO = 1'b0;
         end
         prev_cp = CP; prev_ce = CE_n; prev_pl = PL_n;
      end
      AUTO = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      total_cnt++; if (scans !== 50) $display("FAIL proto_scans got %0d want 50", scans); else pass_cnt++;
      total_cnt++; if (bad_rise !== 0) $display("FAIL proto_cp_rises bad scans %0d want 0", bad_rise); else pass_cnt++;
      total_cnt++; if (bad_phase !== 0) $display("FAIL proto_cp_phase bad phases %0d want 0", bad_phase); else pass_cnt++;
      total_cnt++; if (bad_pl !== 0) $display("FAIL proto_pl_width bad loads %0d want 0", bad_pl); else pass_cnt++;
      total_cnt++; if (overlap !== 0) $display("FAIL proto_cp_during_pl cycles %0d want 0", overlap); else pass_cnt++;
      total_cnt++; if (bad_data !== 0) $display("FAIL proto_data bad words %0d want 0", bad_data); else pass_cnt++;
   endtask

   task automatic test_small_config;
      int vcyc;
      dn2 = 8'h81;
      START2 = 1'b1;
      @(posedge CLK); #1;
      START2 = 1'b0;
      vcyc = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge CLK); #1;
         if (VALID2) begin
            vcyc = n + 1;
            break;
         end
      end
      total_cnt++; if (vcyc !== 77) $display("FAIL small_latency got cycle %0d want 77", vcyc); else pass_cnt++;
      total_cnt++; if (DATA2 !== 8'h81) $display("FAIL small_data got %h want 81", DATA2); else pass_cnt++;
   endtask

   initial begin
      RST_n = 1'b0; START = 1'b0; AUTO = 1'b0;
      START2 = 1'b0; AUTO2 = 1'b0;
      dn0 = 8'h00; dn1 = 8'h00; dn2 = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      test_single_scan();
      test_start_ignored();
      test_auto();
      test_reset_mid_scan();
      test_protocol();
      test_small_config();
      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
